// File: rtl/m_div_unit_if.sv
// Handshake bundle between the operand stage, the divider and writeback.
// The divider takes the slave side; the issuing stage drives the master side.
interface m_div_unit_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [XLEN-1:0]  rs1;
  logic [XLEN-1:0]  rs2;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  modport master (
    output flush, in_valid, op, rs1, rs2, in_tag, out_ready,
    input  in_ready, out_valid, result, out_tag, busy
  );

  modport slave (
    input  flush, in_valid, op, rs1, rs2, in_tag, out_ready,
    output in_ready, out_valid, result, out_tag, busy
  );
endinterface

// File: rtl/m_div_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU, resolving UNROLL quotient
// bits per cycle, with RISC-V divide-by-zero / overflow results and sign fix-up.
module m_div_unit #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1,
  parameter int TAG_W  = 5
) (
  input  logic        clk,
  input  logic        reset,
  m_div_unit_if.slave bus
);
  localparam int DW = 2 * XLEN - 1;
  localparam int N  = XLEN / UNROLL;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state_q;
  logic [XLEN-1:0]  r_q, z_q, result_q;
  logic [DW-1:0]    d_q;
  logic [CW-1:0]    cnt_q;
  logic [1:0]       op_q;
  logic [TAG_W-1:0] tag_q;
  logic             s1_q, s2_q, special_q, out_valid_q;

  // Operand conditioning for the accept cycle
  logic            signed_op, neg1, neg2, div_zero, ovf;
  logic [XLEN-1:0] abs1, abs2;

  assign signed_op = ~bus.op[0];
  assign neg1      = signed_op & bus.rs1[XLEN-1];
  assign neg2      = signed_op & bus.rs2[XLEN-1];
  assign abs1      = neg1 ? ('0 - bus.rs1) : bus.rs1;
  assign abs2      = neg2 ? ('0 - bus.rs2) : bus.rs2;
  assign div_zero  = (bus.rs2 == '0);
  assign ovf       = signed_op && (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (&bus.rs2);

  logic [XLEN-1:0] r_s [UNROLL+1];
  logic [XLEN-1:0] z_s [UNROLL+1];
  logic [DW-1:0]   d_s [UNROLL+1];

  assign r_s[0] = r_q;
  assign z_s[0] = z_q;
  assign d_s[0] = d_q;

  // {0,R} >= D holds only when D has no bits above R's width and the low part fits.
  genvar gi;
  generate
    for (gi = 0; gi < UNROLL; gi++) begin : g_step
      logic [XLEN:0] sub;
      logic          ge;
      assign sub          = {1'b0, r_s[gi]} - {1'b0, d_s[gi][XLEN-1:0]};
      assign ge           = (d_s[gi][DW-1:XLEN] == '0) && !sub[XLEN];
      assign r_s[gi+1]    = ge ? sub[XLEN-1:0] : r_s[gi];
      assign z_s[gi+1]    = {z_s[gi][XLEN-2:0], ge};
      assign d_s[gi+1]    = d_s[gi] >> 1;
    end
  endgenerate

  logic [XLEN-1:0] sel_val, fix_val;
  logic            negate;

  assign sel_val = op_q[1] ? r_q : z_q;
  assign negate  = !special_q && (op_q[1] ? s1_q : (s1_q ^ s2_q));
  assign fix_val = negate ? ('0 - sel_val) : sel_val;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      r_q         <= '0;
      z_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      op_q        <= '0;
      tag_q       <= '0;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      special_q   <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else if (bus.flush) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            op_q  <= bus.op;
            tag_q <= bus.in_tag;
            s1_q  <= neg1;
            s2_q  <= neg2;
            if (div_zero) begin
              r_q       <= bus.rs1;
              z_q       <= '1;
              special_q <= 1'b1;
              state_q   <= FIX;
            end else if (ovf) begin
              r_q       <= '0;
              z_q       <= bus.rs1;
              special_q <= 1'b1;
              state_q   <= FIX;
            end else begin
              r_q       <= abs1;
              z_q       <= '0;
              d_q       <= {abs2, {(XLEN-1){1'b0}}};
              cnt_q     <= '0;
              special_q <= 1'b0;
              state_q   <= CALC;
            end
          end
        end
        CALC: begin
          r_q   <= r_s[UNROLL];
          z_q   <= z_s[UNROLL];
          d_q   <= d_s[UNROLL];
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(N - 1)) state_q <= FIX;
        end
        FIX: begin
          result_q    <= fix_val;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE) && !bus.flush;
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.out_tag   = tag_q;
endmodule

// File: tb/tb_m_div_unit.sv
// Directed bench for m_div_unit: stimulus pushes expected results into a
// scoreboard, a monitor pops and compares on every result handshake.
module tb_m_div_unit;
  localparam int XLEN  = 32;
  localparam int TAG_W = 5;
  parameter  int UNROLL = 1;
  localparam int N = XLEN / UNROLL;

  localparam logic [1:0] OP_DIV = 2'd0, OP_DIVU = 2'd1, OP_REM = 2'd2, OP_REMU = 2'd3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  m_div_unit_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  m_div_unit #(.XLEN(XLEN), .UNROLL(UNROLL), .TAG_W(TAG_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    string            name;
    logic [XLEN-1:0]  res;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  // Monitor: every accepted result must match the oldest outstanding expectation.
  exp_t mon_e;
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected result: got %h tag %h required none", bus.result, bus.out_tag);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, " result"}, 64'(bus.result), 64'(mon_e.res));
        check({mon_e.name, " tag"}, 64'(bus.out_tag), 64'(mon_e.tag));
        $display("[TB] %s -> result %h tag %0d", mon_e.name, bus.result, bus.out_tag);
      end
    end
  end

  task automatic issue(input string name, input logic [1:0] op, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag,
                       input logic [XLEN-1:0] exp_res, input bit push, output int wait_cyc);
    exp_t e;
    wait_cyc = 0;
    @(posedge clk);
    #1;
    bus.op       = op;
    bus.rs1      = a;
    bus.rs2      = b;
    bus.in_tag   = tag;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && wait_cyc < 300) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (!bus.in_ready) check({name, " accept timeout"}, 64'(bus.in_ready), 64'd1);
    if (push) begin
      e.name = name;
      e.res  = exp_res;
      e.tag  = tag;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int exp_lat);
    int lat = 0;
    while (1) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.out_valid || lat >= 300) break;
    end
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic run_vec(input string name, input logic [1:0] op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp_res,
                         input logic [TAG_W-1:0] tag, input bit special);
    int w;
    issue(name, op, a, b, tag, exp_res, 1'b1, w);
    wait_valid(name, special ? 1 : N + 1);
  endtask

  initial begin
    int  w;
    bit  seen;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = '0;
    bus.rs1       = '0;
    bus.rs2       = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    reset         = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", 64'(bus.out_valid), 64'd0);
    check("reset result", 64'(bus.result), 64'd0);
    check("reset out_tag", 64'(bus.out_tag), 64'd0);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset in_ready", 64'(bus.in_ready), 64'd1);
    reset = 1'b0;

    run_vec("DIV -7/2",        OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 5'd17, 1'b0);
    run_vec("REM -7/2",        OP_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 5'd18, 1'b0);
    run_vec("DIVU ffffffff/16", OP_DIVU, 32'hFFFF_FFFF, 32'h10,       32'h0FFF_FFFF, 5'd19, 1'b0);
    run_vec("REMU 789/456",    OP_REMU, 32'd789,       32'd456,       32'd333,       5'd20, 1'b0);
    run_vec("DIV 5/0",         OP_DIV,  32'd5,         32'd0,         32'hFFFF_FFFF, 5'd1,  1'b1);
    run_vec("REM 5/0",         OP_REM,  32'd5,         32'd0,         32'd5,         5'd2,  1'b1);
    run_vec("DIVU 5/0",        OP_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 5'd3,  1'b1);
    run_vec("DIV ovf",         OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 5'd4,  1'b1);
    run_vec("REM ovf",         OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         5'd5,  1'b1);
    run_vec("DIV 1000/-3",     OP_DIV,  32'd1000,      32'hFFFF_FFFD, 32'hFFFF_FEB3, 5'd6,  1'b0);
    run_vec("DIV -20/-3",      OP_DIV,  32'hFFFF_FFEC, 32'hFFFF_FFFD, 32'd6,         5'd7,  1'b0);
    run_vec("REM -20/-3",      OP_REM,  32'hFFFF_FFEC, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 5'd8,  1'b0);
    run_vec("DIVU 80000000/ffffffff", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,  5'd11, 1'b0);

    // Let the last result hand off, then hold the consumer off for ten cycles.
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    run_vec("hold DIVU", OP_DIVU, 32'h1234_5678, 32'h100, 32'h0012_3456, 5'd9, 1'b0);
    bus.in_valid = 1'b1;
    bus.op       = OP_DIV;
    bus.rs1      = 32'd99;
    bus.rs2      = 32'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold result", 64'(bus.result), 64'h0012_3456);
      check("hold out_valid", 64'(bus.out_valid), 64'd1);
      check("hold in_ready", 64'(bus.in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    issue("b2b REMU", OP_REMU, 32'h1234_5678, 32'h100, 5'd10, 32'h78, 1'b1, w);
    check("b2b accept wait", 64'(w), 64'd0);
    wait_valid("b2b REMU", N + 1);

    // Flush part-way through CALC: nothing may come out.
    issue("flushed", OP_DIVU, 32'hFFFF, 32'd3, 5'd12, 32'd0, 1'b0, w);
    repeat (11) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    check("flush busy", 64'(bus.busy), 64'd0);
    check("flush out_valid", 64'(bus.out_valid), 64'd0);
    seen = 1'b0;
    repeat (N + 8) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check("flush no result", 64'(seen), 64'd0);
    run_vec("DIVU 100/7", OP_DIVU, 32'd100, 32'd7, 32'd14, 5'd13, 1'b0);

    // Asynchronous reset pulse between clock edges mid-CALC.
    issue("reset victim", OP_DIV, 32'd1000, 32'd7, 5'd21, 32'd0, 1'b0, w);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async reset out_valid", 64'(bus.out_valid), 64'd0);
    check("async reset busy", 64'(bus.busy), 64'd0);
    check("async reset result", 64'(bus.result), 64'd0);
    check("async reset out_tag", 64'(bus.out_tag), 64'd0);
    #1;
    reset = 1'b0;
    seen = 1'b0;
    repeat (N + 8) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check("reset no result", 64'(seen), 64'd0);
    run_vec("REM 20/-3", OP_REM, 32'd20, 32'hFFFF_FFFD, 32'd2, 5'd22, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
